// File: rtl/input_ctrl.sv
// Router input-port controller: two one-packet VC buffers (even/odd), XY route computed at write,
// one-hot request plus hop-decremented data presented on the buffer matching the current polarity.
module input_ctrl #(
    parameter int DATA_WIDTH = 64,
    parameter int HOP_WIDTH  = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  polarity,
    input  logic                  send_in,
    input  logic [DATA_WIDTH-1:0] data_in,
    output logic                  ready_in,
    input  logic [4:0]            clear_in,
    output logic [4:0]            req_out,
    output logic [DATA_WIDTH-1:0] data_out,
    output logic [1:0]            buf_full,
    output logic                  vc_err
);

    localparam int VC_BIT  = 63;
    localparam int XDIR    = 62;
    localparam int YDIR    = 61;
    localparam int HX_LSB  = 52;
    localparam int HY_LSB  = 48;

    localparam logic [4:0] R_PE = 5'b00001;
    localparam logic [4:0] R_S  = 5'b00010;
    localparam logic [4:0] R_N  = 5'b00100;
    localparam logic [4:0] R_E  = 5'b01000;
    localparam logic [4:0] R_W  = 5'b10000;

    logic [DATA_WIDTH-1:0] data_q  [2];
    logic [4:0]            route_q [2];
    logic [1:0]            full;
    logic                  vc_err_q;

    logic                  wr_idx;
    logic [HOP_WIDTH-1:0]  hop_x;
    logic [HOP_WIDTH-1:0]  hop_y;
    logic [4:0]            route_new;
    logic [DATA_WIDTH-1:0] data_new;
    logic                  vc_ok;
    logic                  accept;

    // The link always targets the buffer of the opposite phase; the current phase's buffer is presented.
    assign wr_idx   = ~polarity;
    assign hop_x    = data_in[HX_LSB +: HOP_WIDTH];
    assign hop_y    = data_in[HY_LSB +: HOP_WIDTH];
    assign ready_in = ~full[wr_idx];
    assign vc_ok    = (data_in[VC_BIT] == wr_idx);
    assign accept   = send_in && ready_in && vc_ok;

    always_comb begin
        route_new = R_PE;
        data_new  = data_in;
        if (hop_x != '0) begin
            route_new = data_in[XDIR] ? R_W : R_E;
            data_new[HX_LSB +: HOP_WIDTH] = hop_x - HOP_WIDTH'(1);
        end else if (hop_y != '0) begin
            route_new = data_in[YDIR] ? R_S : R_N;
            data_new[HY_LSB +: HOP_WIDTH] = hop_y - HOP_WIDTH'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            full       <= '0;
            data_q[0]  <= '0;
            data_q[1]  <= '0;
            route_q[0] <= '0;
            route_q[1] <= '0;
            vc_err_q   <= 1'b0;
        end else begin
            // A full write buffer blocks accept, so write and clear never collide on one buffer.
            if (accept) begin
                data_q[wr_idx]  <= data_new;
                route_q[wr_idx] <= route_new;
                full[wr_idx]    <= 1'b1;
            end else if (|clear_in) begin
                full[wr_idx]    <= 1'b0;
            end
            if (send_in && ready_in && !vc_ok)
                vc_err_q <= 1'b1;
        end
    end

    assign req_out  = full[polarity] ? route_q[polarity] : '0;
    assign data_out = full[polarity] ? data_q[polarity]  : '0;
    assign buf_full = full;
    assign vc_err   = vc_err_q;

endmodule

// File: tb/tb_input_ctrl.sv
// Directed bench for input_ctrl: expected presentations go into a queue, a negedge monitor pops and compares.
module tb_input_ctrl;

    logic        clk = 1'b0;
    logic        reset;
    logic        polarity;
    logic        send_in;
    logic [63:0] data_in;
    logic        ready_in;
    logic [4:0]  clear_in;
    logic [4:0]  req_out;
    logic [63:0] data_out;
    logic [1:0]  buf_full;
    logic        vc_err;

    int unsigned checks = 0;
    int unsigned errors = 0;
    logic        mon_en = 1'b0;
    logic [68:0] exp_q [$];

    input_ctrl #(.DATA_WIDTH(64), .HOP_WIDTH(4)) dut (
        .clk(clk), .reset(reset), .polarity(polarity), .send_in(send_in),
        .data_in(data_in), .ready_in(ready_in), .clear_in(clear_in),
        .req_out(req_out), .data_out(data_out), .buf_full(buf_full), .vc_err(vc_err)
    );

    always #5 clk = ~clk;

    // Packets and their hand-computed presented form (route one-hot, hop field after decrement)
    localparam logic [63:0] P1  = 64'h0032_1234_5678_9ABC; // vc0 E hop_x 3
    localparam logic [63:0] P1E = 64'h0022_1234_5678_9ABC;
    localparam logic [63:0] P2  = 64'h0000_CAFE_F00D_1234; // vc0 PE
    localparam logic [63:0] P3  = 64'hC010_0000_0000_0055; // vc1 W hop_x 1
    localparam logic [63:0] P3E = 64'hC000_0000_0000_0055;
    localparam logic [63:0] P4  = 64'hA005_0000_0000_0077; // vc1 S hop_y 5
    localparam logic [63:0] P4E = 64'hA004_0000_0000_0077;
    localparam logic [63:0] P5  = 64'h0001_0000_0000_0011; // vc0 N hop_y 1
    localparam logic [63:0] P5E = 64'h0000_0000_0000_0011;
    localparam logic [63:0] BAD = 64'h0030_0000_0000_00EE; // vc0 offered on an even cycle

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Drive one cycle's inputs just after the edge, return mid-cycle for direct checks.
    task automatic cyc(input logic s, input logic [63:0] d, input logic [4:0] clr);
        @(posedge clk);
        #1;
        polarity = ~polarity;
        send_in  = s;
        data_in  = d;
        clear_in = clr;
        #3;
    endtask

    always @(negedge clk) begin
        if (mon_en && req_out != '0) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_req: got req %b data %h expected none", req_out, data_out);
            end else begin
                logic [68:0] e;
                e = exp_q.pop_front();
                if ({req_out, data_out} !== e) begin
                    errors++;
                    $display("FAIL present: got req %b data %h expected req %b data %h",
                             req_out, data_out, e[68:64], e[63:0]);
                end
            end
        end
    end

    initial begin
        reset    = 1'b1;
        polarity = 1'b0;
        send_in  = 1'b0;
        data_in  = '0;
        clear_in = '0;

        cyc(0, '0, '0);                 // pol1, reset
        cyc(0, '0, '0);                 // pol0, reset
        reset = 1'b0;
        cyc(0, '0, '0);                 // pol1
        chk("rst_req", 64'(req_out), 64'h0);
        chk("rst_data", data_out, 64'h0);
        chk("rst_full", 64'(buf_full), 64'h0);
        chk("rst_ready", 64'(ready_in), 64'h1);
        chk("rst_vcerr", 64'(vc_err), 64'h0);
        mon_en = 1'b1;
        cyc(0, '0, '0);                 // pol0

        // East packet, then stall with no grant across six cycles plus the grant cycle
        repeat (4) exp_q.push_back({5'b01000, P1E});
        cyc(1, P1, '0);                 // A pol1
        chk("a_ready", 64'(ready_in), 64'h1);
        cyc(0, '0, '0);                 // A+1 pol0 presents
        chk("a1_full", 64'(buf_full), 64'h1);
        cyc(1, P2, '0);                 // A+2 pol1, buffer 0 full -> ignored
        chk("a2_ready", 64'(ready_in), 64'h0);
        chk("a2_req", 64'(req_out), 64'h0);
        cyc(0, '0, '0);                 // A+3 presents
        cyc(0, '0, '0);                 // A+4
        chk("a4_ready", 64'(ready_in), 64'h0);
        cyc(0, '0, '0);                 // A+5 presents
        cyc(0, '0, '0);                 // A+6
        cyc(0, '0, '0);                 // A+7 presents, granted
        cyc(0, '0, 5'b01000);           // A+8 pol1 clear
        chk("a8_ready", 64'(ready_in), 64'h0);
        chk("a8_req", 64'(req_out), 64'h0);
        cyc(0, '0, '0);                 // A+9 pol0
        chk("a9_full", 64'(buf_full), 64'h0);
        chk("a9_req", 64'(req_out), 64'h0);

        // Local-delivery packet, header untouched; multi-hot clear
        exp_q.push_back({5'b00001, P2});
        cyc(1, P2, '0);                 // A+10 pol1
        chk("a10_ready", 64'(ready_in), 64'h1);
        cyc(0, '0, '0);                 // A+11 presents
        cyc(0, '0, 5'b10001);           // A+12 clear buffer 0

        // Both buffers in flight: W on odd buffer, N on even buffer
        exp_q.push_back({5'b10000, P3E});
        cyc(1, P3, '0);                 // A+13 pol0
        chk("a13_full", 64'(buf_full), 64'h0);
        exp_q.push_back({5'b00100, P5E});
        cyc(1, P5, '0);                 // A+14 pol1 presents P3
        chk("a14_full", 64'(buf_full), 64'h2);
        cyc(0, '0, 5'b10000);           // A+15 pol0 presents P5, clears odd
        chk("a15_full", 64'(buf_full), 64'h3);
        cyc(0, '0, 5'b00100);           // A+16 pol1 clears even
        cyc(0, '0, 5'b00001);           // A+17 pol0 clear on empty odd buffer
        chk("a17_full", 64'(buf_full), 64'h0);
        cyc(0, '0, '0);                 // A+18
        chk("a18_full", 64'(buf_full), 64'h0);

        // South packet on odd buffer
        exp_q.push_back({5'b00010, P4E});
        cyc(1, P4, '0);                 // A+19 pol0
        cyc(0, '0, '0);                 // A+20 presents
        cyc(0, '0, 5'b00010);           // A+21 clear odd
        cyc(0, '0, '0);                 // A+22
        chk("a22_full", 64'(buf_full), 64'h0);

        // VC mismatch dropped, sticky error
        cyc(1, BAD, '0);                // A+23 pol0
        chk("a23_vcerr", 64'(vc_err), 64'h0);
        exp_q.push_back({5'b01000, P1E});
        cyc(1, P1, '0);                 // A+24 pol1
        chk("a24_vcerr", 64'(vc_err), 64'h1);
        chk("a24_full", 64'(buf_full), 64'h0);
        cyc(0, '0, '0);                 // A+25 presents P1
        chk("a25_vcerr", 64'(vc_err), 64'h1);
        chk("a25_full", 64'(buf_full), 64'h1);
        reset = 1'b1;

        // Mid-operation reset discards the pending packet
        cyc(0, '0, '0);                 // A+26 pol1
        reset = 1'b0;
        chk("mr_full", 64'(buf_full), 64'h0);
        chk("mr_ready", 64'(ready_in), 64'h1);
        chk("mr_vcerr", 64'(vc_err), 64'h0);
        cyc(0, '0, '0);                 // A+27 pol0, would have re-requested
        chk("mr_req", 64'(req_out), 64'h0);
        chk("mr_data", data_out, 64'h0);
        cyc(0, '0, '0);

        chk("queue_left", 64'(exp_q.size()), 64'h0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
